// File: rtl/hazard_fwd_unit.sv
// Pipeline hazard tracking for the MIPS datapath: carries each decoded writer through
// EX/MEM/WB and derives operand forwarding, decode bypass and load-use stall control.
package the_pkg;
    parameter int BR = 5;

    typedef struct packed {
        logic          valid;
        logic [BR-1:0] rs;
        logic [BR-1:0] rt;
        logic          uses_rs;
        logic          uses_rt;
        logic [BR-1:0] dest;
        logic          regwrite;
        logic          memread;
    } ex_slot_t;

    typedef struct packed {
        logic          valid;
        logic [BR-1:0] dest;
        logic          regwrite;
        logic          memread;
    } wr_slot_t;
endpackage

module hazard_fwd_unit
    import the_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    input  logic [BR-1:0] id_rs,
    input  logic [BR-1:0] id_rt,
    input  logic          id_uses_rs,
    input  logic          id_uses_rt,
    input  logic [BR-1:0] id_dest,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          flush,
    output logic          stall,
    output logic [1:0]    fwd_a,
    output logic [1:0]    fwd_b,
    output logic          byp_a,
    output logic          byp_b,
    output logic [CW-1:0] stall_cnt
);

    ex_slot_t ex_q;
    wr_slot_t mem_q;
    wr_slot_t wb_q;

    logic ex_live;
    logic mem_live;
    logic wb_live;

    // Register 0 is hard-wired to zero, so a write to it never creates a dependency.
    function automatic logic is_live(input logic v, input logic rw, input logic [BR-1:0] d);
        return v & rw & (d != '0);
    endfunction

    // MEM holds the younger writer, so it wins over WB.
    function automatic logic [1:0] fwd_sel(input logic en, input logic [BR-1:0] src,
                                           input logic m_live, input logic [BR-1:0] m_dest,
                                           input logic w_live, input logic [BR-1:0] w_dest);
        if (!en)                            return 2'b00;
        else if (m_live && m_dest == src)   return 2'b10;
        else if (w_live && w_dest == src)   return 2'b01;
        else                                return 2'b00;
    endfunction

    assign ex_live  = is_live(ex_q.valid,  ex_q.regwrite,  ex_q.dest);
    assign mem_live = is_live(mem_q.valid, mem_q.regwrite, mem_q.dest);
    assign wb_live  = is_live(wb_q.valid,  wb_q.regwrite,  wb_q.dest);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        stall = 1'b0;
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        byp_a = 1'b0;
        byp_b = 1'b0;

        if (ex_live && ex_q.memread && id_valid &&
            ((id_uses_rs && id_rs == ex_q.dest) || (id_uses_rt && id_rt == ex_q.dest)))
            stall = 1'b1;

        fwd_a = fwd_sel(ex_q.valid & ex_q.uses_rs, ex_q.rs, mem_live, mem_q.dest, wb_live, wb_q.dest);
        fwd_b = fwd_sel(ex_q.valid & ex_q.uses_rt, ex_q.rt, mem_live, mem_q.dest, wb_live, wb_q.dest);

        byp_a = id_valid & id_uses_rs & wb_live & (wb_q.dest == id_rs);
        byp_b = id_valid & id_uses_rt & wb_live & (wb_q.dest == id_rt);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every slot shifts on the same edge.
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
        end else begin
            mem_q <= {ex_q.valid, ex_q.dest, ex_q.regwrite, ex_q.memread};
            wb_q  <= mem_q;

            // A flush coinciding with a stall still inserts only one bubble.
            if (flush || stall)
                ex_q <= '0;
            else
                ex_q <= {id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
                         id_dest, id_regwrite, id_memread};

            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CW'(1);
        end
    end

    // The load flag retires with the WB slot; nothing downstream reads it here.
    logic unused_wb_memread;
    assign unused_wb_memread = wb_q.memread;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Randomized scoreboard bench for hazard_fwd_unit: a queue-based pipeline model predicts
// each cycle's outputs; a negedge monitor compares them against two DUT instances.
module tb_hazard_fwd_unit;
    import the_pkg::*;

    localparam int CW   = 16;
    localparam int CWS  = 3;
    localparam int MAXC = (1 << CW) - 1;
    localparam int MAXS = (1 << CWS) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_memread, flush;
    logic [BR-1:0] id_rs, id_rt, id_dest;
    logic          stall, byp_a, byp_b;
    logic [1:0]    fwd_a, fwd_b;
    logic [CW-1:0] stall_cnt;
    logic          s_stall, s_byp_a, s_byp_b;
    logic [1:0]    s_fwd_a, s_fwd_b;
    logic [CWS-1:0] s_cnt;

    hazard_fwd_unit #(.CW(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .byp_a(byp_a), .byp_b(byp_b),
        .stall_cnt(stall_cnt)
    );

    // Narrow counter instance so saturation is reachable in a short run.
    hazard_fwd_unit #(.CW(CWS)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(s_stall), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .byp_a(s_byp_a), .byp_b(s_byp_b),
        .stall_cnt(s_cnt)
    );

    typedef struct {
        bit v; int rs; int rt; bit urs; bit urt; int dest; bit rw; bit mr;
    } ins_t;

    typedef struct {
        string name; bit stall; int fa; int fb; bit ba; bit bb; int cnt; int cnt_s;
    } exp_t;

    // Model: pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB (age order, youngest first).
    ins_t pipe[3];
    bit   known = 1'b0;
    int   m_cnt = 0;
    bit   m_stall;
    bit   m_rst;
    bit   m_flush;
    ins_t m_id;
    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic ins_t mk(bit v, int rs, int rt, bit urs, bit urt, int dest, bit rw, bit mr);
        ins_t x;
        x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt; x.dest = dest; x.rw = rw; x.mr = mr;
        return x;
    endfunction

    function automatic ins_t nop();
        return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic ins_t alu(int dest, int rs, int rt);
        return mk(1, rs, rt, 1, 1, dest, 1, 0);
    endfunction

    function automatic ins_t ld(int dest, int rs);
        return mk(1, rs, 0, 1, 0, dest, 1, 1);
    endfunction

    function automatic bit live(ins_t x);
        return x.v && x.rw && x.dest != 0;
    endfunction

    // Search older slots youngest-first for the most recent live writer of r.
    function automatic int fwd_model(int r, bit uses);
        if (!pipe[0].v || !uses) return 0;
        for (int k = 1; k <= 2; k++)
            if (live(pipe[k]) && pipe[k].dest == r) return (k == 1) ? 2 : 1;
        return 0;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one decode cycle and queue the outputs the model predicts for it.
    task automatic apply(string name, bit rst, ins_t i, bit fl);
        exp_t e;
        rst_n = rst; flush = fl;
        id_valid = i.v; id_rs = BR'(i.rs); id_rt = BR'(i.rt);
        id_uses_rs = i.urs; id_uses_rt = i.urt; id_dest = BR'(i.dest);
        id_regwrite = i.rw; id_memread = i.mr;
        m_rst = rst; m_flush = fl; m_id = i;
        m_stall = live(pipe[0]) && pipe[0].mr && i.v &&
                  ((i.urs && i.rs == pipe[0].dest) || (i.urt && i.rt == pipe[0].dest));
        if (known) begin
            e.name  = name;
            e.stall = m_stall;
            e.fa    = fwd_model(pipe[0].rs, pipe[0].urs);
            e.fb    = fwd_model(pipe[0].rt, pipe[0].urt);
            e.ba    = i.v && i.urs && live(pipe[2]) && pipe[2].dest == i.rs;
            e.bb    = i.v && i.urt && live(pipe[2]) && pipe[2].dest == i.rt;
            e.cnt   = (m_cnt > MAXC) ? MAXC : m_cnt;
            e.cnt_s = (m_cnt > MAXS) ? MAXS : m_cnt;
            sbq.push_back(e);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (!m_rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = nop();
            m_cnt = 0;
            known = 1'b1;
        end else begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (m_flush || m_stall) ? nop() : m_id;
            if (m_stall) m_cnt++;
        end
    endtask

    task automatic step(string name, bit rst, ins_t i, bit fl);
        apply(name, rst, i, fl);
        advance();
    endtask

    function automatic ins_t rnd_ins();
        return mk(($urandom_range(0, 99) < 85), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                  ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 30));
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk({e.name, ".stall"}, int'(stall), int'(e.stall));
                chk({e.name, ".fwd_a"}, int'(fwd_a), e.fa);
                chk({e.name, ".fwd_b"}, int'(fwd_b), e.fb);
                chk({e.name, ".byp_a"}, int'(byp_a), int'(e.ba));
                chk({e.name, ".byp_b"}, int'(byp_b), int'(e.bb));
                chk({e.name, ".stall_cnt"}, int'(stall_cnt), e.cnt);
                chk({e.name, ".s_stall"}, int'(s_stall), int'(e.stall));
                chk({e.name, ".s_fwd_a"}, int'(s_fwd_a), e.fa);
                chk({e.name, ".s_fwd_b"}, int'(s_fwd_b), e.fb);
                chk({e.name, ".s_byp"}, int'({s_byp_a, s_byp_b}), int'({e.ba, e.bb}));
                chk({e.name, ".s_cnt"}, int'(s_cnt), e.cnt_s);
            end
        end
    end

    initial begin : driver
        ins_t rdr;

        // Reset held two cycles under random decode inputs.
        step("rst0", 0, rnd_ins(), 1'($urandom_range(0, 1)));
        step("rst1", 0, rnd_ins(), 1'($urandom_range(0, 1)));
        apply("post_rst", 1, alu(3, 3, 3), 0);
        #1;
        chk("post_rst_stall", int'(stall), 0);
        chk("post_rst_fwd", int'({fwd_a, fwd_b}), 0);
        chk("post_rst_cnt", int'(stall_cnt), 0);
        advance();
        repeat (3) step("flush_pipe", 1, nop(), 0);

        // ALU back-to-back, then with one independent instruction between.
        step("b2b_w", 1, alu(3, 1, 2), 0);
        step("b2b_r", 1, alu(7, 3, 4), 0);
        apply("b2b_ex", 1, nop(), 0); #1; chk("b2b_fwd_a_mem", int'(fwd_a), 2); advance();
        repeat (3) step("idle", 1, nop(), 0);
        step("gap_w", 1, alu(3, 1, 2), 0);
        step("gap_i", 1, alu(10, 11, 12), 0);
        step("gap_r", 1, alu(7, 3, 4), 0);
        apply("gap_ex", 1, nop(), 0); #1; chk("gap_fwd_a_wb", int'(fwd_a), 1); advance();
        repeat (3) step("idle", 1, nop(), 0);

        // Two writers of $5; the younger one (in MEM) must win.
        step("pri_w1", 1, alu(5, 1, 2), 0);
        step("pri_w2", 1, alu(5, 2, 3), 0);
        step("pri_r", 1, alu(6, 5, 0), 0);
        apply("pri_ex", 1, nop(), 0); #1; chk("pri_fwd_a", int'(fwd_a), 2); advance();
        repeat (3) step("idle", 1, nop(), 0);

        // Load-use: one stall, bubble, then the load sits in WB when the reader is in EX.
        rdr = mk(1, 2, 8, 0, 1, 9, 1, 0);
        step("lu_ld", 1, ld(8, 1), 0);
        apply("lu_stall", 1, rdr, 0); #1; chk("lu_stall_on", int'(stall), 1); advance();
        apply("lu_go", 1, rdr, 0); #1; chk("lu_stall_off", int'(stall), 0); advance();
        apply("lu_ex", 1, nop(), 0); #1;
        chk("lu_fwd_b", int'(fwd_b), 1);
        chk("lu_cnt", int'(stall_cnt), 1);
        advance();
        repeat (3) step("idle", 1, nop(), 0);

        // Register zero never forwards, stalls or bypasses.
        step("z_w", 1, mk(1, 1, 2, 1, 1, 0, 1, 1), 0);
        apply("z_r", 1, alu(11, 0, 0), 0); #1; chk("z_stall", int'(stall), 0); advance();
        apply("z_ex", 1, alu(12, 0, 0), 0); #1;
        chk("z_fwd_a", int'(fwd_a), 0);
        chk("z_byp_a", int'(byp_a), 0);
        advance();
        repeat (3) step("idle", 1, nop(), 0);

        // Flushed writer of $9 leaves nothing to forward.
        step("fl_w", 1, alu(9, 1, 2), 1);
        step("fl_r", 1, alu(12, 9, 9), 0);
        apply("fl_ex", 1, nop(), 0); #1; chk("fl_fwd", int'({fwd_a, fwd_b}), 0); advance();
        repeat (3) step("idle", 1, nop(), 0);

        // Writer of $4 reaches WB while a $4 reader is in decode.
        step("byp_w", 1, alu(4, 1, 2), 0);
        step("byp_n1", 1, nop(), 0);
        step("byp_n2", 1, nop(), 0);
        apply("byp_r", 1, alu(13, 4, 0), 0); #1; chk("byp_a_on", int'(byp_a), 1); advance();
        repeat (3) step("idle", 1, nop(), 0);

        // Drive the narrow counter past its maximum.
        repeat (10) begin
            step("sat_ld", 1, ld(8, 1), 0);
            step("sat_st", 1, alu(9, 8, 8), 0);
            step("sat_go", 1, alu(9, 8, 8), 0);
        end
        apply("sat_chk", 1, nop(), 0); #1; chk("sat_hold", int'(s_cnt), MAXS); advance();

        // Randomized traffic with small register range and occasional reset.
        for (int n = 0; n < 3000; n++)
            step("rnd", ($urandom_range(0, 199) != 0), rnd_ins(), ($urandom_range(0, 9) == 0));

        apply("tail", 1, nop(), 0);
        advance();
        @(negedge clk);
        #1;
        chk("sb_drain", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
